step_dir_decoder: RTL

- Receive-side counterpart of the stepper driver's STEP/DIR/EN_N outputs.
- Samples an external STEP/DIR/EN_N bundle, qualifies step pulses against A4988 minimum-width timing, and accumulates a signed step position.
- Measures the step period and reports motion status and timing violations.
- Used as a loopback monitor on the motor interface and as a position tracker for the top-level controller.

---
 rtl/step_dir_decoder_if.sv | 29 ++
 rtl/step_dir_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/step_dir_decoder_if.sv
// STEP/DIR/EN_N receive bundle plus position/period status for step_dir_decoder.
// The master drives the external pins and clear requests; the slave (decoder) reports status.
interface step_dir_decoder_if #(
  parameter int POS_W    = 32,
  parameter int PERIOD_W = 32
);
  logic                       step_in;
  logic                       dir_in;
  logic                       en_n_in;
  logic                       clear_pos;
  logic                       clear_glitch;
  logic signed [POS_W-1:0]    position;
  logic        [PERIOD_W-1:0] period;
  logic                       period_valid;
  logic                       moving;
  logic                       step_strobe;
  logic                       glitch;
  logic        [15:0]         glitch_count;

  modport master (
    output step_in, dir_in, en_n_in, clear_pos, clear_glitch,
    input  position, period, period_valid, moving, step_strobe, glitch, glitch_count
  );

  modport slave (
    input  step_in, dir_in, en_n_in, clear_pos, clear_glitch,
    output position, period, period_valid, moving, step_strobe, glitch, glitch_count
  );
endinterface

// File: rtl/step_dir_decoder.sv
// Qualifies external STEP pulses against minimum high/low widths and tracks signed position and step period.
// Define STEP_DIR_GLITCH_CNT_EN to build the saturating rejected-pulse counter.
module step_dir_decoder #(
  parameter int MIN_HIGH = 100,
  parameter int MIN_LOW  = 100,
  parameter int POS_W    = 32,
  parameter int PERIOD_W = 32,
  parameter int TIMEOUT  = 100000000
) (
  input  logic               clock,
  input  logic               reset,
  step_dir_decoder_if.slave  bus
);

  localparam int CNT_MAX = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    HI_SAT    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]    LO_SAT    = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);
  localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1);

  typedef enum logic {ST_LOW, ST_HIGH} state_e;

  state_e              state_q, state_d;
  logic                step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_s3_q, step_s3_d;
  logic                dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
  logic                en_s1_q, en_s1_d, en_s2_q, en_s2_d;
  logic [CNT_W-1:0]    lo_cnt_q, lo_cnt_d, hi_cnt_q, hi_cnt_d;
  logic                dir_lat_q, dir_lat_d, en_lat_q, en_lat_d, bad_q, bad_d;
  logic [POS_W-1:0]    position_q, position_d;
  logic [PERIOD_W-1:0] period_q, period_d, pcnt_q, pcnt_d;
  logic                period_valid_q, period_valid_d, ref_q, ref_d;
  logic                moving_q, moving_d, step_strobe_q, step_strobe_d, glitch_q, glitch_d;
  logic                rise, fall, commit, reject;

  assign rise = step_s2_q & ~step_s3_q;
  assign fall = ~step_s2_q & step_s3_q;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    step_s1_d      = bus.step_in;
    step_s2_d      = step_s1_q;
    step_s3_d      = step_s2_q;
    dir_s1_d       = bus.dir_in;
    dir_s2_d       = dir_s1_q;
    en_s1_d        = bus.en_n_in;
    en_s2_d        = en_s1_q;
    lo_cnt_d       = lo_cnt_q;
    hi_cnt_d       = hi_cnt_q;
    dir_lat_d      = dir_lat_q;
    en_lat_d       = en_lat_q;
    bad_d          = bad_q;
    position_d     = position_q;
    period_d       = period_q;
    pcnt_d         = pcnt_q;
    period_valid_d = period_valid_q;
    ref_d          = ref_q;
    moving_d       = moving_q;
    step_strobe_d  = 1'b0;
    glitch_d       = glitch_q;
    commit         = 1'b0;
    reject         = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (rise) begin
          state_d   = ST_HIGH;
          hi_cnt_d  = CNT_ONE;
          dir_lat_d = dir_s2_q;
          en_lat_d  = en_s2_q;
          bad_d     = (lo_cnt_q < LO_SAT);
        end else if (lo_cnt_q < LO_SAT) begin
          lo_cnt_d = lo_cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d  = ST_LOW;
          lo_cnt_d = CNT_ONE;
          // A well-formed pulse on a disabled driver is neither a step nor a glitch.
          if (hi_cnt_q >= HI_SAT && !bad_q) commit = ~en_lat_q;
          else                              reject = 1'b1;
        end else if (hi_cnt_q < HI_SAT) begin
          hi_cnt_d = hi_cnt_q + CNT_ONE;
        end
      end
    endcase

    if (bus.clear_pos)  position_d = '0;
    else if (commit)    position_d = dir_lat_q ? position_q + POS_ONE : position_q - POS_ONE;

    if (commit) begin
      step_strobe_d = 1'b1;
      moving_d      = 1'b1;
      pcnt_d        = PER_ONE;
      ref_d         = 1'b1;
      if (ref_q) begin
        period_d       = pcnt_q;
        period_valid_d = 1'b1;
      end
    end else begin
      if (pcnt_q != '1) pcnt_d = pcnt_q + PER_ONE;
      // Period output deliberately keeps its last value across a timeout.
      if (pcnt_q == TIMEOUT_V) begin
        moving_d       = 1'b0;
        period_valid_d = 1'b0;
        ref_d          = 1'b0;
      end
    end

    if (reject)                glitch_d = 1'b1;
    else if (bus.clear_glitch) glitch_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_LOW;
      step_s1_q      <= 1'b0;
      step_s2_q      <= 1'b0;
      step_s3_q      <= 1'b0;
      dir_s1_q       <= 1'b0;
      dir_s2_q       <= 1'b0;
      en_s1_q        <= 1'b0;
      en_s2_q        <= 1'b0;
      lo_cnt_q       <= LO_SAT;
      hi_cnt_q       <= '0;
      dir_lat_q      <= 1'b0;
      en_lat_q       <= 1'b0;
      bad_q          <= 1'b0;
      position_q     <= '0;
      period_q       <= '0;
      pcnt_q         <= '0;
      period_valid_q <= 1'b0;
      ref_q          <= 1'b0;
      moving_q       <= 1'b0;
      step_strobe_q  <= 1'b0;
      glitch_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      step_s1_q      <= step_s1_d;
      step_s2_q      <= step_s2_d;
      step_s3_q      <= step_s3_d;
      dir_s1_q       <= dir_s1_d;
      dir_s2_q       <= dir_s2_d;
      en_s1_q        <= en_s1_d;
      en_s2_q        <= en_s2_d;
      lo_cnt_q       <= lo_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      dir_lat_q      <= dir_lat_d;
      en_lat_q       <= en_lat_d;
      bad_q          <= bad_d;
      position_q     <= position_d;
      period_q       <= period_d;
      pcnt_q         <= pcnt_d;
      period_valid_q <= period_valid_d;
      ref_q          <= ref_d;
      moving_q       <= moving_d;
      step_strobe_q  <= step_strobe_d;
      glitch_q       <= glitch_d;
    end
  end

`ifdef STEP_DIR_GLITCH_CNT_EN
  logic [15:0] glitch_count_q, glitch_count_d;

  always_comb begin
    glitch_count_d = glitch_count_q;
    if (bus.clear_glitch)                    glitch_count_d = reject ? 16'd1 : 16'd0;
    else if (reject && glitch_count_q != '1) glitch_count_d = glitch_count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) glitch_count_q <= '0;
    else       glitch_count_q <= glitch_count_d;
  end

  assign bus.glitch_count = glitch_count_q;
`else
  assign bus.glitch_count = '0;
`endif

  assign bus.position     = position_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.moving       = moving_q;
  assign bus.step_strobe  = step_strobe_q;
  assign bus.glitch       = glitch_q;

endmodule
